pong_frame_ctrl: RTL and testbench

Frame-rate game controller for Pong. It advances paddle and ball positions once per video frame, resolves wall, paddle and goal collisions, keeps score, and sequences the serve/play/game-over flow. It sits beside the VGA timing generator, which supplies a one-cycle `frame_tick` at the start of vertical blanking. The pixel renderer reads this block's registered position outputs and compares them against the active-video `hcount`/`vcount`.

---
 rtl/pong_frame_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pong_frame_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_frame_ctrl.sv
// Pong game controller: paddle and ball motion, collision resolution, scoring and
// the serve/play/point/over sequence, stepped once per frame_tick in vertical blanking.
module pong_frame_ctrl #(
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 4,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       p1_up,
  input  logic       p1_dn,
  input  logic       p2_up,
  input  logic       p2_dn,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] pad1_y,
  output logic [9:0] pad2_y,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [2:0] state,
  output logic       busy,
  output logic       game_over
);
  localparam int STAGES = 2;
  localparam logic [9:0]         BALL_X0  = 10'd316;
  localparam logic [9:0]         BALL_Y0  = 10'd236;
  localparam logic [9:0]         PAD_Y0   = 10'd208;
  localparam logic [9:0]         PAD_MAX  = 10'd416;
  localparam logic [9:0]         PSTEP    = 10'(PADDLE_SPEED);
  localparam logic signed [10:0] BSTEP    = 11'(BALL_SPEED);
  localparam logic [15:0]        SERVE_LD = 16'(SERVE_FRAMES);
  localparam logic [3:0]         WIN      = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } st_t;

  st_t                st, st_nxt;
  logic [STAGES:0]    vld_pipe, vld_nxt;
  logic               go;
  logic               dx, dy;        // 1 = moving toward larger x / y
  logic [15:0]        serve_cnt;
  logic signed [10:0] nx, ny;        // provisional position, signed so underflow shows
  logic               p1_scored;
  logic [9:0]         cx, cy;
  logic               cdx, cdy, hit1, hit2, goal1, goal2, win;
  logic [3:0]         new_score;

  function automatic logic [9:0] pad_step(input logic [9:0] y, input logic up,
                                          input logic dn);
    logic [10:0] sum;
    sum      = {1'b0, y} + {1'b0, PSTEP};
    pad_step = y;
    if (up && !dn)      pad_step = (y < PSTEP) ? 10'd0 : y - PSTEP;
    else if (dn && !up) pad_step = (sum > {1'b0, PAD_MAX}) ? PAD_MAX : sum[9:0];
  endfunction

  function automatic logic overlap(input logic [9:0] by, input logic [9:0] py);
    overlap = (({1'b0, by} + 11'd8) > {1'b0, py}) && ({1'b0, by} < ({1'b0, py} + 11'd64));
  endfunction

  // U3: walls first, then paddles against the wall-clamped y, then goals
  always_comb begin
    cy  = ny[9:0];
    cdy = dy;
    if (ny <= 11'sd0) begin
      cy  = 10'd0;
      cdy = 1'b1;
    end else if (ny >= 11'sd472) begin
      cy  = 10'd472;
      cdy = 1'b0;
    end
    hit1 = !dx && (nx <= 11'sd24) && overlap(cy, pad1_y);
    hit2 = dx && (nx >= 11'sd608) && overlap(cy, pad2_y);
    cx   = nx[9:0];
    cdx  = dx;
    if (hit1) begin
      cx  = 10'd24;
      cdx = 1'b1;
    end else if (hit2) begin
      cx  = 10'd608;
      cdx = 1'b0;
    end
    goal2 = !hit1 && !hit2 && (nx <= 11'sd0);
    goal1 = !hit1 && !hit2 && (nx >= 11'sd632);
  end

  always_comb begin
    new_score = (p1_scored ? score1 : score2) + 4'd1;
    win       = (new_score == WIN);
    st_nxt    = st;
    go        = 1'b0;
    case (st)
      IDLE, OVER: if (start) st_nxt = SERVE;
      SERVE: begin
        go = frame_tick && !busy;
        if (vld_pipe[0] && (serve_cnt == 16'd0)) st_nxt = PLAY;
      end
      PLAY: begin
        go = frame_tick && !busy;
        if (vld_pipe[STAGES] && (goal1 || goal2)) st_nxt = POINT;
      end
      POINT:   st_nxt = win ? OVER : SERVE;
      default: st_nxt = IDLE;
    endcase
    // serve ticks stop after the paddle stage; play ticks run all three
    vld_nxt = {vld_pipe[STAGES-1:1], vld_pipe[0] && (st == PLAY), go};
  end

  always_ff @(posedge clk) begin
    if (reset) st <= IDLE;
    else       st <= st_nxt;
  end

  assign state = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe  <= '0;
      busy      <= 1'b0;
      game_over <= 1'b0;
      ball_x    <= BALL_X0;
      ball_y    <= BALL_Y0;
      pad1_y    <= PAD_Y0;
      pad2_y    <= PAD_Y0;
      score1    <= 4'd0;
      score2    <= 4'd0;
      dx        <= 1'b1;
      dy        <= 1'b1;
      serve_cnt <= 16'd0;
      nx        <= 11'sd0;
      ny        <= 11'sd0;
      p1_scored <= 1'b0;
    end else begin
      vld_pipe  <= vld_nxt;
      busy      <= |vld_nxt;
      game_over <= (st_nxt == OVER);
      if (vld_pipe[0]) begin
        pad1_y <= pad_step(pad1_y, p1_up, p1_dn);
        pad2_y <= pad_step(pad2_y, p2_up, p2_dn);
        if ((st == SERVE) && (serve_cnt != 16'd0)) serve_cnt <= serve_cnt - 16'd1;
      end
      if (vld_pipe[1]) begin
        nx <= dx ? $signed({1'b0, ball_x}) + BSTEP : $signed({1'b0, ball_x}) - BSTEP;
        ny <= dy ? $signed({1'b0, ball_y}) + BSTEP : $signed({1'b0, ball_y}) - BSTEP;
      end
      if (vld_pipe[STAGES]) begin
        if (goal1 || goal2) begin
          p1_scored <= goal1;
        end else begin
          ball_x <= cx;
          ball_y <= cy;
          dx     <= cdx;
          dy     <= cdy;
        end
      end
      if (((st == IDLE) || (st == OVER)) && start) begin
        score1    <= 4'd0;
        score2    <= 4'd0;
        ball_x    <= BALL_X0;
        ball_y    <= BALL_Y0;
        serve_cnt <= SERVE_LD;
      end
      if (st == POINT) begin
        if (p1_scored) score1 <= new_score;
        else           score2 <= new_score;
        // a winning point leaves the ball where it went out
        if (!win) begin
          ball_x    <= BALL_X0;
          ball_y    <= BALL_Y0;
          serve_cnt <= SERVE_LD;
          dx        <= p1_scored;
        end
      end
    end
  end
endmodule

// File: tb/tb_pong_frame_ctrl.sv
// Directed bench for pong_frame_ctrl: plays one full game along hand-traced ball paths.
module tb_pong_frame_ctrl;
  logic       clk = 1'b0, reset = 1'b1, frame_tick = 1'b0, start = 1'b0;
  logic       p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
  logic [9:0] ball_x, ball_y, pad1_y, pad2_y;
  logic [3:0] score1, score2;
  logic [2:0] state;
  logic       busy, game_over;
  int         checks = 0, errors = 0;

  pong_frame_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
    .ball_x(ball_x), .ball_y(ball_y), .pad1_y(pad1_y), .pad2_y(pad2_y),
    .score1(score1), .score2(score2), .state(state), .busy(busy), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // one frame: pulse the tick, then give the update and any POINT cycle time to settle
  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({ball_x, ball_y, pad1_y, pad2_y} !== {10'd316, 10'd236, 10'd208, 10'd208}) begin
      errors++;
      $display("FAIL reset_pos got ball (%0d,%0d) pads %0d/%0d exp (316,236) 208/208", ball_x, ball_y, pad1_y, pad2_y);
    end
    checks++;
    if ({score1, score2, state, busy, game_over} !== {4'd0, 4'd0, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctl got s1=%0d s2=%0d st=%0d busy=%0d go=%0d exp 0 0 0 0 0", score1, score2, state, busy, game_over);
    end
    p1_up = 1'b1; p2_dn = 1'b1;
    ticks(2);
    p1_up = 1'b0; p2_dn = 1'b0;
    checks++;
    if ({pad1_y, pad2_y, state, busy} !== {10'd208, 10'd208, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL idle_ignore got pads %0d/%0d st=%0d busy=%0d exp 208/208 0 0", pad1_y, pad2_y, state, busy);
    end
  endtask

  task automatic test_start();
    pulse_start();
    checks++;
    if ({state, score1, score2} !== {3'd1, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL start got st=%0d s1=%0d s2=%0d exp 1 0 0", state, score1, score2);
    end
  endtask

  // serve ticks 1..54: both-pressed hold, then saturate p1 up and p2 down
  task automatic test_paddle_clamp();
    p1_up = 1'b1; p1_dn = 1'b1; p2_up = 1'b1; p2_dn = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL serve_busy_e0 got %0d exp 1", busy);
    end
    @(negedge clk);
    checks++;
    if ({busy, pad1_y, pad2_y} !== {1'b0, 10'd208, 10'd208}) begin
      errors++;
      $display("FAIL serve_both got busy=%0d pads %0d/%0d exp 0 208/208", busy, pad1_y, pad2_y);
    end
    repeat (4) @(negedge clk);
    p1_dn = 1'b0; p2_up = 1'b0;
    ticks(51);
    checks++;
    if ({pad1_y, pad2_y} !== {10'd4, 10'd412}) begin
      errors++; $display("FAIL clamp_51 got pads %0d/%0d exp 4/412", pad1_y, pad2_y);
    end
    tick();
    checks++;
    if ({pad1_y, pad2_y} !== {10'd0, 10'd416}) begin
      errors++; $display("FAIL clamp_52 got pads %0d/%0d exp 0/416", pad1_y, pad2_y);
    end
    tick();
    checks++;
    if ({pad1_y, pad2_y} !== {10'd0, 10'd416}) begin
      errors++; $display("FAIL clamp_53 got pads %0d/%0d exp 0/416", pad1_y, pad2_y);
    end
    p1_up = 1'b0; p2_dn = 1'b0;
  endtask

  task automatic test_serve_countdown();
    ticks(6);
    checks++;
    if ({state, ball_x, ball_y} !== {3'd1, 10'd316, 10'd236}) begin
      errors++; $display("FAIL serve_60 got st=%0d ball (%0d,%0d) exp 1 (316,236)", state, ball_x, ball_y);
    end
    tick();
    checks++;
    if ({state, ball_x, ball_y} !== {3'd2, 10'd316, 10'd236}) begin
      errors++; $display("FAIL serve_61 got st=%0d ball (%0d,%0d) exp 2 (316,236)", state, ball_x, ball_y);
    end
  endtask

  task automatic test_wall_bounce();
    ticks(117);
    checks++;
    if ({ball_x, ball_y} !== {10'd550, 10'd470}) begin
      errors++; $display("FAIL wall_pre got (%0d,%0d) exp (550,470)", ball_x, ball_y);
    end
    tick();
    checks++;
    if ({ball_x, ball_y} !== {10'd552, 10'd472}) begin
      errors++; $display("FAIL wall_hit got (%0d,%0d) exp (552,472)", ball_x, ball_y);
    end
    // stage-by-stage view of one play frame, with p1 moving down
    p1_dn = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    checks++;
    if ({busy, pad1_y} !== {1'b1, 10'd0}) begin
      errors++; $display("FAIL play_e0 got busy=%0d pad1=%0d exp 1 0", busy, pad1_y);
    end
    @(negedge clk);
    checks++;
    if ({busy, pad1_y, ball_x, ball_y} !== {1'b1, 10'd4, 10'd552, 10'd472}) begin
      errors++; $display("FAIL play_e1 got busy=%0d pad1=%0d ball (%0d,%0d) exp 1 4 (552,472)", busy, pad1_y, ball_x, ball_y);
    end
    p1_dn = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, ball_x, ball_y} !== {1'b1, 10'd552, 10'd472}) begin
      errors++; $display("FAIL play_e2 got busy=%0d ball (%0d,%0d) exp 1 (552,472)", busy, ball_x, ball_y);
    end
    @(negedge clk);
    checks++;
    if ({busy, ball_x, ball_y} !== {1'b0, 10'd554, 10'd470}) begin
      errors++; $display("FAIL play_e3 got busy=%0d ball (%0d,%0d) exp 0 (554,470)", busy, ball_x, ball_y);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_paddle2_hit();
    ticks(26);
    checks++;
    if ({ball_x, ball_y} !== {10'd606, 10'd418}) begin
      errors++; $display("FAIL p2hit_pre got (%0d,%0d) exp (606,418)", ball_x, ball_y);
    end
    tick();
    checks++;
    if ({ball_x, ball_y} !== {10'd608, 10'd416}) begin
      errors++; $display("FAIL p2hit got (%0d,%0d) exp (608,416)", ball_x, ball_y);
    end
    tick();
    checks++;
    if ({ball_x, ball_y} !== {10'd606, 10'd414}) begin
      errors++; $display("FAIL p2hit_post got (%0d,%0d) exp (606,414)", ball_x, ball_y);
    end
  endtask

  // pad1 sits at 4, ball reaches x=24 at y=168: no overlap, so it passes and scores
  task automatic test_miss();
    ticks(291);
    checks++;
    if ({ball_x, ball_y} !== {10'd24, 10'd168}) begin
      errors++; $display("FAIL miss_x24 got (%0d,%0d) exp (24,168)", ball_x, ball_y);
    end
    ticks(11);
    checks++;
    if ({ball_x, ball_y, state} !== {10'd2, 10'd190, 3'd2}) begin
      errors++; $display("FAIL miss_x2 got (%0d,%0d) st=%0d exp (2,190) 2", ball_x, ball_y, state);
    end
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({state, busy, score2, ball_x, ball_y} !== {3'd3, 1'b0, 4'd0, 10'd2, 10'd190}) begin
      errors++; $display("FAIL goal_e3 got st=%0d busy=%0d s2=%0d ball (%0d,%0d) exp 3 0 0 (2,190)", state, busy, score2, ball_x, ball_y);
    end
    @(negedge clk);
    checks++;
    if ({state, score1, score2, ball_x, ball_y} !== {3'd1, 4'd0, 4'd1, 10'd316, 10'd236}) begin
      errors++; $display("FAIL goal_e4 got st=%0d s1=%0d s2=%0d ball (%0d,%0d) exp 1 0 1 (316,236)", state, score1, score2, ball_x, ball_y);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_paddle1_hit();
    p1_dn = 1'b1;
    ticks(61);
    tick();
    checks++;
    if ({state, ball_x, ball_y} !== {3'd2, 10'd314, 10'd238}) begin
      errors++; $display("FAIL serve_left got st=%0d ball (%0d,%0d) exp 2 (314,238)", state, ball_x, ball_y);
    end
    ticks(144);
    checks++;
    if ({ball_x, ball_y, pad1_y} !== {10'd26, 10'd418, 10'd416}) begin
      errors++; $display("FAIL p1hit_pre got (%0d,%0d) pad1=%0d exp (26,418) 416", ball_x, ball_y, pad1_y);
    end
    tick();
    checks++;
    if ({ball_x, ball_y} !== {10'd24, 10'd416}) begin
      errors++; $display("FAIL p1hit got (%0d,%0d) exp (24,416)", ball_x, ball_y);
    end
    p1_dn = 1'b0;
    tick();
    checks++;
    if ({ball_x, ball_y} !== {10'd26, 10'd414}) begin
      errors++; $display("FAIL p1hit_post got (%0d,%0d) exp (26,414)", ball_x, ball_y);
    end
  endtask

  task automatic test_point_p1();
    ticks(302);
    checks++;
    if ({ball_x, ball_y, state} !== {10'd630, 10'd190, 3'd2}) begin
      errors++; $display("FAIL p1pt_pre got (%0d,%0d) st=%0d exp (630,190) 2", ball_x, ball_y, state);
    end
    tick();
    checks++;
    if ({state, score1, score2, ball_x, ball_y} !== {3'd1, 4'd1, 4'd1, 10'd316, 10'd236}) begin
      errors++; $display("FAIL p1pt got st=%0d s1=%0d s2=%0d ball (%0d,%0d) exp 1 1 1 (316,236)", state, score1, score2, ball_x, ball_y);
    end
    p1_up = 1'b1;
    ticks(52);
    p1_up = 1'b0;
    ticks(9);
    tick();
    checks++;
    if ({pad1_y, ball_x, ball_y} !== {10'd208, 10'd318, 10'd238}) begin
      errors++; $display("FAIL serve_right got pad1=%0d ball (%0d,%0d) exp 208 (318,238)", pad1_y, ball_x, ball_y);
    end
  endtask

  task automatic test_win();
    ticks(449);
    checks++;
    if ({state, score1, score2} !== {3'd1, 4'd1, 4'd2}) begin
      errors++; $display("FAIL score2_2 got st=%0d s1=%0d s2=%0d exp 1 1 2", state, score1, score2);
    end
    for (int s = 3; s <= 7; s++) begin
      logic [9:0] ey;
      logic [2:0] est;
      ey  = (s % 2 == 1) ? 10'd394 : 10'd78;
      est = (s == 7) ? 3'd4 : 3'd1;
      ticks(61 + 157);
      checks++;
      if ({ball_x, ball_y} !== {10'd2, ey}) begin
        errors++; $display("FAIL rally%0d_pre got (%0d,%0d) exp (2,%0d)", s, ball_x, ball_y, ey);
      end
      tick();
      checks++;
      if ({state, score2, score1} !== {est, 4'(s), 4'd1}) begin
        errors++; $display("FAIL rally%0d got st=%0d s2=%0d s1=%0d exp %0d %0d 1", s, state, score2, score1, est, s);
      end
    end
  endtask

  task automatic test_over();
    p1_up = 1'b1; p2_up = 1'b1;
    ticks(3);
    p1_up = 1'b0; p2_up = 1'b0;
    checks++;
    if ({ball_x, ball_y, pad1_y, pad2_y} !== {10'd2, 10'd394, 10'd208, 10'd416}) begin
      errors++; $display("FAIL over_hold got ball (%0d,%0d) pads %0d/%0d exp (2,394) 208/416", ball_x, ball_y, pad1_y, pad2_y);
    end
    checks++;
    if ({state, game_over, busy, score2} !== {3'd4, 1'b1, 1'b0, 4'd7}) begin
      errors++; $display("FAIL over_ctl got st=%0d go=%0d busy=%0d s2=%0d exp 4 1 0 7", state, game_over, busy, score2);
    end
    pulse_start();
    checks++;
    if ({state, game_over, score1, score2, ball_x, ball_y} !== {3'd1, 1'b0, 4'd0, 4'd0, 10'd316, 10'd236}) begin
      errors++; $display("FAIL restart got st=%0d go=%0d s1=%0d s2=%0d ball (%0d,%0d) exp 1 0 0 0 (316,236)", state, game_over, score1, score2, ball_x, ball_y);
    end
  endtask

  task automatic test_reset_mid();
    ticks(61 + 3);
    checks++;
    if ({state, ball_x, ball_y} !== {3'd2, 10'd310, 10'd230}) begin
      errors++; $display("FAIL replay got st=%0d ball (%0d,%0d) exp 2 (310,230)", state, ball_x, ball_y);
    end
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({ball_x, ball_y, pad1_y, pad2_y} !== {10'd316, 10'd236, 10'd208, 10'd208}) begin
      errors++; $display("FAIL rst_mid_pos got ball (%0d,%0d) pads %0d/%0d exp (316,236) 208/208", ball_x, ball_y, pad1_y, pad2_y);
    end
    checks++;
    if ({state, busy, game_over} !== {3'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rst_mid_ctl got st=%0d busy=%0d go=%0d exp 0 0 0", state, busy, game_over);
    end
    repeat (4) @(negedge clk);
    pulse_start();
    ticks(61);
    tick();
    checks++;
    if ({ball_x, ball_y} !== {10'd318, 10'd238}) begin
      errors++; $display("FAIL rst_dir got (%0d,%0d) exp (318,238)", ball_x, ball_y);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_paddle_clamp();
    test_serve_countdown();
    test_wall_bounce();
    test_paddle2_hit();
    test_miss();
    test_paddle1_hit();
    test_point_p1();
    test_win();
    test_over();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
